// File: rtl/sdram_readback_checker.sv
// sdram_readback_checker: re-pairs SDRAM read-back words into 32-bit counter samples and checks their continuity
//  clk           in   system clock, all logic on posedge
//  n_rst         in   asynchronous active-low reset
//  en            in   check enable
//  clr           in   synchronous clear of counters and capture registers
//  d, d_valid    in   16-bit read-back word and its valid strobe
//  samples       out  samples checked (wraps)
//  errs          out  mismatch count (saturating)
//  err_sticky    out  set on first mismatch
//  locked        out  checker is in CHECK
//  first_err_*   out  sample index, expected and received value at the first mismatch
module sdram_readback_checker #(
   parameter bit LOW_FIRST = 1'b1,
   parameter int ERR_W     = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic [15:0]      d,
   input  logic             d_valid,
   output logic [31:0]      samples,
   output logic [ERR_W-1:0] errs,
   output logic             err_sticky,
   output logic             locked,
   output logic [31:0]      first_err_idx,
   output logic [31:0]      first_err_exp,
   output logic [31:0]      first_err_got
);
   typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;
   state_t state, state_nx;
   logic phase, take, done, miss;
   logic [15:0] half;
   logic [31:0] expected, sample;
   assign locked = state == CHECK;
   always_comb begin
      take = d_valid && en && !clr && state != IDLE;
      done = take && phase;
      sample = LOW_FIRST ? {d, half} : {half, d};
      miss = done && state == CHECK && sample != expected;
      state_nx = clr ? (en ? SEED : IDLE) : !en ? IDLE : state == IDLE ? SEED : done ? CHECK : state;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         phase         <= 1'b0;
         half          <= '0;
         expected      <= '0;
         samples       <= '0;
         errs          <= '0;
         err_sticky    <= 1'b0;
         first_err_idx <= '0;
         first_err_exp <= '0;
         first_err_got <= '0;
      end else begin
         state <= state_nx;
         // a pending half word survives only while enabled, active and not cleared
         phase <= take ? !phase : phase && en && !clr && state != IDLE;
         if (take && !phase) half <= d;
         if (clr) begin
            expected      <= '0;
            samples       <= '0;
            errs          <= '0;
            err_sticky    <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
         end else if (done) begin
            samples  <= samples + 32'd1;
            // on a match sample equals expected, so sample+1 covers seed, match and resync alike
            expected <= sample + 32'd1;
            if (miss) begin
               if (!(&errs)) errs <= errs + ERR_W'(1);
               if (!err_sticky) begin
                  first_err_idx <= samples;
                  first_err_exp <= expected;
                  first_err_got <= sample;
                  err_sticky    <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sdram_readback_checker.sv
// tb_sdram_readback_checker: randomized self-checking bench against a sample-level reference model
module tb_sdram_readback_checker;
   localparam bit LF = 1'b1;
   localparam int EW = 4;
   logic clk = 1'b0, n_rst = 1'b0, en = 1'b0, clr = 1'b0, d_valid = 1'b0;
   logic [15:0] d = '0;
   logic [31:0] samples, first_err_idx, first_err_exp, first_err_got;
   logic [EW-1:0] errs;
   logic err_sticky, locked;
   int n_checks = 0, n_fail = 0;
   int m_st, m_errs;
   bit m_ph, m_sticky;
   logic [15:0] m_half;
   logic [31:0] m_exp, m_smp, m_idx, m_fexp, m_got;
   always #5 clk = ~clk;
   sdram_readback_checker #(.LOW_FIRST(LF), .ERR_W(EW)) dut (
      .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
      .samples(samples), .errs(errs), .err_sticky(err_sticky), .locked(locked),
      .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_st = 0; m_ph = 0; m_half = '0; m_exp = '0; m_smp = '0;
      m_errs = 0; m_sticky = 0; m_idx = '0; m_fexp = '0; m_got = '0;
   endtask
   task automatic check_all(input string tag);
      check({tag, ".samples"}, samples, m_smp);
      check({tag, ".errs"}, 32'(errs), m_errs[31:0]);
      check({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
      check({tag, ".locked"}, 32'(locked), 32'(m_st == 2));
      check({tag, ".idx"}, first_err_idx, m_idx);
      check({tag, ".fexp"}, first_err_exp, m_fexp);
      check({tag, ".got"}, first_err_got, m_got);
   endtask
   // one clock of stimulus; the model applies the same cycle's rules, DUT is sampled 1 ns after the edge
   task automatic step(input bit e, input bit c, input bit v, input logic [15:0] w);
      logic [31:0] s;
      @(negedge clk);
      en = e; clr = c; d_valid = v; d = w;
      if (c) begin
         model_reset();
         m_st = e ? 1 : 0;
      end else if (!e) begin
         m_st = 0; m_ph = 0;
      end else if (m_st == 0) m_st = 1;
      else if (v) begin
         if (!m_ph) begin
            m_half = w; m_ph = 1;
         end else begin
            m_ph = 0;
            s = LF ? {w, m_half} : {m_half, w};
            if (m_st == 2 && s != m_exp) begin
               if (m_errs < 2**EW - 1) m_errs++;
               if (!m_sticky) begin
                  m_idx = m_smp; m_fexp = m_exp; m_got = s; m_sticky = 1;
               end
            end
            m_st = 2; m_smp++; m_exp = s + 32'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic send_sample(input logic [31:0] s, input int gap);
      step(1, 0, 1, LF ? s[15:0] : s[31:16]);
      repeat (gap) step(1, 0, 0, '0);
      step(1, 0, 1, LF ? s[31:16] : s[15:0]);
   endtask
   initial begin
      logic [31:0] cnt;
      bit hi;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      n_rst = 1'b1;
      step(1, 0, 0, '0);
      check("seed.locked", 32'(locked), 32'd0);
      for (int i = 0; i < 1024; i++) send_sample(i, 0);
      check_all("t1");
      check("t1.samples_abs", samples, 32'd1024);
      check("t1.errs_abs", 32'(errs), 32'd0);
      check("t1.locked_abs", 32'(locked), 32'd1);
      step(1, 1, 0, '0);
      send_sample(32'hFFFF_FFFE, $urandom_range(0, 2));
      send_sample(32'hFFFF_FFFF, $urandom_range(0, 2));
      send_sample(32'h0000_0000, $urandom_range(0, 2));
      send_sample(32'h0000_0001, $urandom_range(0, 2));
      check_all("t2");
      check("t2.samples_abs", samples, 32'd4);
      check("t2.errs_abs", 32'(errs), 32'd0);
      step(1, 1, 0, '0);
      for (int i = 0; i < 100; i++) send_sample(i == 50 ? 32'h1234_5678 : i, $urandom_range(0, 1));
      check_all("t3");
      check("t3.errs_abs", 32'(errs), 32'd2);
      check("t3.idx_abs", first_err_idx, 32'd50);
      check("t3.exp_abs", first_err_exp, 32'd50);
      check("t3.got_abs", first_err_got, 32'h1234_5678);
      step(1, 1, 0, '0);
      for (int i = 0; i < 20; i++) send_sample(i, 0);
      step(1, 0, 1, 16'd20);
      for (int i = 21; i < 40; i++) send_sample(i, $urandom_range(0, 1));
      check_all("t4");
      check("t4.sticky_abs", 32'(err_sticky), 32'd1);
      for (int i = 0; i < 40; i++) send_sample($urandom, 0);
      check_all("t4.sat");
      check("t4.sat_abs", 32'(errs), 32'd15);
      step(1, 1, 1, 16'($urandom));
      check_all("t5.clr");
      check("t5.samples_abs", samples, 32'd0);
      check("t5.locked_abs", 32'(locked), 32'd0);
      send_sample(32'd777, 1);
      send_sample(32'd778, 0);
      check_all("t5.reseed");
      check("t5.errs_abs", 32'(errs), 32'd0);
      step(1, 0, 1, 16'hABCD);
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      check_all("t6.rst");
      @(negedge clk);
      en = 1'b0;
      n_rst = 1'b1;
      step(1, 0, 0, '0);
      for (int i = 100; i < 110; i++) send_sample(i, 0);
      step(1, 0, 1, 16'd110);
      step(0, 0, 0, '0);
      check_all("t6.drop");
      check("t6.samples_abs", samples, 32'd10);
      step(0, 0, 1, 16'h5555);
      step(1, 0, 0, '0);
      send_sample(32'd500, 0);
      send_sample(32'd501, 2);
      check_all("t6.resume");
      check("t6.errs_abs", 32'(errs), 32'd0);
      cnt = $urandom;
      hi = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] w;
         bit v;
         v = $urandom_range(0, 2) != 0;
         w = ($urandom_range(0, 49) == 0) ? 16'($urandom) : (hi == LF) ? cnt[31:16] : cnt[15:0];
         if (v) begin
            if (hi) cnt++;
            hi = !hi;
         end
         step($urandom_range(0, 59) != 0, $urandom_range(0, 199) == 0, v, w);
         check_all("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
